// File: rtl/gshare_index.sv
// gshare_index: index-policy stage in front of the pattern history table.
//
// The PHT lookup index is the FETCH PC XORed with a speculative global
// branch history. Each prediction made at lookup is shifted into that
// history right away. The stage tracks the one prediction in flight until
// DECODE resolves it. On a wrong prediction the speculative history is
// rebuilt from the committed history, which holds resolved outcomes only.
//
// Optional feature: define GSHARE_STATS_EN to add the stat_resolves and
// stat_mispredicts counter outputs. Without it those ports do not exist.
module gshare_index #(
    parameter int IWIDTH = 6,   // PHT index width, must match the PHT
    parameter int HWIDTH = 4,   // global history length, 2..IWIDTH
    parameter int PC_LSB = 2    // lowest PC bit used in the index
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              lookup_valid,
    input  logic [31:0]       pc,
    input  logic              pred,
    input  logic              resolve_valid,
    input  logic              resolve_taken,
    output logic [IWIDTH-1:0] index,
    output logic [HWIDTH-1:0] spec_hist,
    output logic              mispredict
`ifdef GSHARE_STATS_EN
    ,
    output logic [31:0]       stat_resolves,
    output logic [31:0]       stat_mispredicts
`endif
);

    // Architectural state
    logic [HWIDTH-1:0] r_spec_hist;    // history including unresolved predictions
    logic [HWIDTH-1:0] r_commit_hist;  // history of resolved outcomes only
    logic              r_pend_valid;   // a prediction is waiting in DECODE
    logic              r_pend_pred;    // the direction that was predicted

    // Combinational helpers
    logic [IWIDTH-1:0] w_hist_ext;     // spec history zero-extended to IWIDTH
    logic [IWIDTH-1:0] w_pc_field;     // PC bits that select the PHT entry
    logic              w_accept;       // DECODE resolve matches a pending record
    logic              w_mispredict;   // accepted resolve disagrees with prediction
    logic [HWIDTH-1:0] w_commit_next;  // committed history with this outcome appended
    logic [HWIDTH-1:0] w_spec_shift;   // spec history with the new prediction appended
    logic              w_unused_bits;  // PC bits outside the field and the oldest commit bit

    // History occupies the low bits of the index. Bits above HWIDTH are
    // zero, so those bits come straight from the PC.
    for (genvar gi = 0; gi < IWIDTH; gi++) begin : g_hist_ext
        if (gi < HWIDTH) begin : g_hist_bit
            assign w_hist_ext[gi] = r_spec_hist[gi];
        end else begin : g_zero_bit
            assign w_hist_ext[gi] = 1'b0;
        end
    end

    assign w_pc_field    = pc[PC_LSB +: IWIDTH];
    assign w_accept      = resolve_valid && r_pend_valid;
    assign w_mispredict  = en && w_accept && (resolve_taken != r_pend_pred);
    assign w_commit_next = {r_commit_hist[HWIDTH-2:0], resolve_taken};
    assign w_spec_shift  = {r_spec_hist[HWIDTH-2:0], pred};

    // Index depends only on registered history and pc. That keeps a
    // combinational path through the PHT and back into pred from forming.
    assign index      = w_pc_field ^ w_hist_ext;
    assign spec_hist  = r_spec_hist;
    assign mispredict = w_mispredict;

    // The byte-offset and high PC bits are not used by the index. The oldest
    // committed bit only ever shifts out.
    assign w_unused_bits = ^{pc, r_commit_hist[HWIDTH-1]};

    // Update the committed and speculative histories and the pending record.
    // A repair takes priority over a same-cycle lookup, which is on the wrong path.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_spec_hist   <= '0;
            r_commit_hist <= '0;
            r_pend_valid  <= 1'b0;
            r_pend_pred   <= 1'b0;
        end else if (en) begin
            if (w_accept) begin
                r_commit_hist <= w_commit_next;
            end

            if (w_mispredict) begin
                r_spec_hist  <= w_commit_next;
                r_pend_valid <= 1'b0;
            end else if (lookup_valid) begin
                r_spec_hist  <= w_spec_shift;
                r_pend_valid <= 1'b1;
                r_pend_pred  <= pred;
            end else begin
                r_pend_valid <= 1'b0;
            end
        end
    end

`ifdef GSHARE_STATS_EN
    logic [31:0] r_stat_resolves;
    logic [31:0] r_stat_mispredicts;

    // Event counters that wrap freely. Both count only while the pipeline advances.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stat_resolves    <= 32'd0;
            r_stat_mispredicts <= 32'd0;
        end else begin
            if (en && w_accept) begin
                r_stat_resolves <= r_stat_resolves + 32'd1;
            end
            if (w_mispredict) begin
                r_stat_mispredicts <= r_stat_mispredicts + 32'd1;
            end
        end
    end

    assign stat_resolves    = r_stat_resolves;
    assign stat_mispredicts = r_stat_mispredicts;
`endif

endmodule
